tile_draw_arbiter: RTL and testbench
====================================

# tile_draw_arbiter

- Rectangle-fill engine and two-way arbiter in front of the `vga_adapter` pixel-write port of the piano-tiles design.
- Two requesters each present a rectangle: origin, size and colour. Typical requesters are the tile renderer and the erase/background renderer.
- The block grants one requester at a time and sweeps the rectangle in raster order.
- It drives one pixel per clock into `vga_adapter` (x, y, colour, write), then pulses a per-requester done.

## Interface

Parameters:
- `X_W`, 10, x coordinate width
- `Y_W`, 9, y coordinate width
- `COLOR_W`, 3, colour width
- `X_MAX`, 640, first off-screen column
- `Y_MAX`, 480, first off-screen row

Ports:
- `clock`  in  1  system clock (CLOCK_50 domain); the only clock
- `reset`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  rectangle request, held until the matching done
- `x0_0` / `x0_1`  in  X_W  rectangle left column
- `y0_0` / `y0_1`  in  Y_W  rectangle top row
- `w_0` / `w_1`  in  X_W  width in pixels
- `h_0` / `h_1`  in  Y_W  height in pixels
- `col_0` / `col_1`  in  COLOR_W  fill colour
- `done0` / `done1`  out  1  one-cycle completion pulse
- `vga_x`  out  X_W  pixel column to vga_adapter `x`
- `vga_y`  out  Y_W  pixel row to vga_adapter `y`
- `vga_colour`  out  COLOR_W  to vga_adapter `colour`
- `vga_write`  out  1  to vga_adapter `write`
- `busy`  out  1  high in any state other than IDLE

## Operation

States and transitions:
- IDLE: if any req is high, choose a grant, latch that requester's x0/y0/w/h/col, clear cx/cy, and go to DRAW. If the latched w or h is 0, go to DONE instead.
- DRAW: present pixel (x0+cx, y0+cy) with the latched colour.
  - cx increments each cycle.
  - When cx == w-1: cx clears and cy increments.
  - After the pixel with cx == w-1 and cy == h-1, go to DONE.
- DONE: pulse `done` of the granted requester for one cycle, then go to IDLE.

Data rules:
- Parameters are latched at grant. Requester input changes or a dropped req during DRAW are ignored, and the draw completes.
- Arithmetic: x0+cx is formed in X_W+1 bits and y0+cy in Y_W+1 bits.
- Clipping: when the sum is ≥ X_MAX (column) or ≥ Y_MAX (row), `vga_write`=0 for that cycle. The sweep still advances, so DRAW always lasts exactly w*h cycles.
- Arbitration with both req high in IDLE: grant the requester not granted last. The last-grant pointer resets to "1", so req0 wins the first contention.
- A requester that keeps req high through its done cycle is re-granted in the following IDLE cycle if it wins arbitration.
- Outputs when not in DRAW: `vga_write`=0. `vga_x`, `vga_y` and `vga_colour` hold their last values and are don't-care.

## Timing

- Reset: state IDLE, every output 0 (`vga_x`, `vga_y`, `vga_colour`, `vga_write`, `done0`, `done1`, `busy`), pointer = 1.
- Reset mid-draw: the sweep is abandoned, no done pulse is issued, and the requester must re-request.
- Grant edge: the rising edge on which IDLE samples req.
- First pixel write is visible in the cycle after the grant edge. All outputs are registered.
- DRAW occupies w*h consecutive cycles with no stalls. `vga_adapter` accepts one write per clock.
- The done pulse occurs in the cycle immediately after the last DRAW cycle. With w or h equal to 0, done occurs in the cycle after the grant edge and there are no writes.
- Minimum spacing between the last pixel of one rectangle and the first pixel of the next: 2 cycles (DONE, IDLE grant).
- `busy` rises in the cycle after the grant edge and falls in the cycle after DONE.

## Configuration

- `TILE_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority. req0 always wins contention, the pointer is not implemented, and req1 is granted only when req0 is low in IDLE.

## Test plan

1. Single draw.
   - Stimulus: req0 with (10,20), w=3, h=2, col=5.
   - Required: six writes, in order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all colour 5.
   - Required: done0 in the cycle after the last write; busy high for 7 cycles.
2. Contention after reset (macro defined).
   - Stimulus: req0 and req1 raised on the same cycle.
   - Required: req0 is served first, then req1 is granted 2 cycles after done0, then done1 pulses.
   - Required: a second simultaneous contention grants req1 first.
3. Clipping.
   - Stimulus: req1 with (638,479), w=4, h=2.
   - Required: writes only at (638,479) and (639,479); DRAW lasts 8 cycles; done1 follows.
4. Zero size.
   - Stimulus: req0 with w=0, h=5.
   - Required: no `vga_write`; done0 in the cycle after the grant edge.
5. Reset mid-draw.
   - Stimulus: assert reset on the 3rd pixel of a 4x4 draw.
   - Required: all outputs 0 in the next cycle, no done0, state IDLE.
6. Macro undefined.
   - Stimulus: both reqs held continuously.
   - Required: req0 is granted repeatedly and req1 never, until req0 drops.

Source files
------------

// File: rtl/tile_draw_arbiter.sv
// Rectangle-fill engine with a two-way arbiter feeding the vga_adapter pixel-write port.
// Define TILE_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build is fixed priority (req0 wins).
module tile_draw_arbiter #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 3,
    parameter int X_MAX   = 640,
    parameter int Y_MAX   = 480
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic [X_W-1:0]     x0_0,
    input  logic [X_W-1:0]     x0_1,
    input  logic [Y_W-1:0]     y0_0,
    input  logic [Y_W-1:0]     y0_1,
    input  logic [X_W-1:0]     w_0,
    input  logic [X_W-1:0]     w_1,
    input  logic [Y_W-1:0]     h_0,
    input  logic [Y_W-1:0]     h_1,
    input  logic [COLOR_W-1:0] col_0,
    input  logic [COLOR_W-1:0] col_1,
    output logic               done0,
    output logic               done1,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_write,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [X_W:0]   X_LIM = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0]   Y_LIM = (Y_W + 1)'(Y_MAX);
    localparam logic [X_W-1:0] X_ONE = 1;
    localparam logic [Y_W-1:0] Y_ONE = 1;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic [X_W-1:0]       x0_q, x0_d;
    logic [Y_W-1:0]       y0_q, y0_d;
    logic [X_W-1:0]       w_q, w_d;
    logic [Y_W-1:0]       h_q, h_d;
    logic [COLOR_W-1:0]   col_q, col_d;
    logic [X_W-1:0]       cx_q, cx_d;
    logic [Y_W-1:0]       cy_q, cy_d;

    logic [X_W-1:0]       vga_x_q, vga_x_d;
    logic [Y_W-1:0]       vga_y_q, vga_y_d;
    logic [COLOR_W-1:0]   vga_colour_q, vga_colour_d;
    logic                 vga_write_q, vga_write_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic                 busy_q, busy_d;

    logic                 grant_sel;
    logic [X_W-1:0]       sel_w;
    logic [Y_W-1:0]       sel_h;
    logic [X_W:0]         x_sum;
    logic [Y_W:0]         y_sum;

`ifdef TILE_ARB_ROUND_ROBIN_EN
    logic                 last_q, last_d;

    // Under contention the requester not granted last wins.
    always_comb begin
        grant_sel = (req0 && req1) ? ~last_q : req1;
    end
`else
    always_comb begin
        grant_sel = ~req0;
    end
`endif

    always_comb begin
        sel_w = grant_sel ? w_1 : w_0;
        sel_h = grant_sel ? h_1 : h_0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            col_q        <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_write_q  <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
`ifdef TILE_ARB_ROUND_ROBIN_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            w_q          <= w_d;
            h_q          <= h_d;
            col_q        <= col_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_write_q  <= vga_write_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            busy_q       <= busy_d;
`ifdef TILE_ARB_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    // cx_q/cy_q always name the pixel currently on the outputs while in DRAW.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
`ifdef TILE_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = grant_sel;
`ifdef TILE_ARB_ROUND_ROBIN_EN
                    last_d  = grant_sel;
`endif
                    x0_d    = grant_sel ? x0_1 : x0_0;
                    y0_d    = grant_sel ? y0_1 : y0_0;
                    w_d     = sel_w;
                    h_d     = sel_h;
                    col_d   = grant_sel ? col_1 : col_0;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (sel_w == '0 || sel_h == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (cx_q == w_q - X_ONE) begin
                    cx_d = '0;
                    if (cy_q == h_q - Y_ONE) begin
                        state_d = DONE;
                    end else begin
                        cy_d = cy_q + Y_ONE;
                    end
                end else begin
                    cx_d = cx_q + X_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so the first pixel appears right after the grant edge.
    always_comb begin
        x_sum        = {1'b0, x0_d} + {1'b0, cx_d};
        y_sum        = {1'b0, y0_d} + {1'b0, cy_d};
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_write_d  = 1'b0;
        if (state_d == DRAW) begin
            vga_x_d      = x_sum[X_W-1:0];
            vga_y_d      = y_sum[Y_W-1:0];
            vga_colour_d = col_d;
            vga_write_d  = (x_sum < X_LIM) && (y_sum < Y_LIM);
        end
        done0_d = (state_d == DONE) && !grant_d;
        done1_d = (state_d == DONE) && grant_d;
        busy_d  = (state_d != IDLE);
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_write  = vga_write_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// Directed bench for tile_draw_arbiter; expectations follow TILE_ARB_ROUND_ROBIN_EN when it is defined.
module tb_tile_draw_arbiter;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic               req0, req1;
    logic [X_W-1:0]     x0_0, x0_1, w_0, w_1;
    logic [Y_W-1:0]     y0_0, y0_1, h_0, h_1;
    logic [COLOR_W-1:0] col_0, col_1;
    logic               done0, done1, vga_write, busy;
    logic [X_W-1:0]     vga_x;
    logic [Y_W-1:0]     vga_y;
    logic [COLOR_W-1:0] vga_colour;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tile_draw_arbiter #(
        .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .X_MAX(640), .Y_MAX(480)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1),
        .x0_0(x0_0), .x0_1(x0_1), .y0_0(y0_0), .y0_1(y0_1),
        .w_0(w_0), .w_1(w_1), .h_0(h_0), .h_1(h_1),
        .col_0(col_0), .col_1(col_1),
        .done0(done0), .done1(done1),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_write(vga_write), .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic which, input int x, input int y, input int w,
                                 input int h, input int col, input logic req);
        if (which) begin
            x0_1 = X_W'(x); y0_1 = Y_W'(y); w_1 = X_W'(w); h_1 = Y_W'(h); col_1 = COLOR_W'(col); req1 = req;
        end else begin
            x0_0 = X_W'(x); y0_0 = Y_W'(y); w_0 = X_W'(w); h_0 = Y_W'(h); col_0 = COLOR_W'(col); req0 = req;
        end
    endtask

    task automatic expectPixel(input string tag, input int x, input int y, input int col);
        checkOutput({tag, "_write"}, 32'(vga_write), 32'd1);
        checkOutput({tag, "_x"}, 32'(vga_x), 32'(x));
        checkOutput({tag, "_y"}, 32'(vga_y), 32'(y));
        checkOutput({tag, "_colour"}, 32'(vga_colour), 32'(col));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done"}, 32'({done1, done0}), 32'd0);
    endtask

    task automatic expectBlank(input string tag);
        checkOutput({tag, "_write"}, 32'(vga_write), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done"}, 32'({done1, done0}), 32'd0);
    endtask

    task automatic expectDone(input string tag, input logic d0, input logic d1);
        checkOutput({tag, "_write"}, 32'(vga_write), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done0"}, 32'(done0), 32'(d0));
        checkOutput({tag, "_done1"}, 32'(done1), 32'(d1));
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, "_write"}, 32'(vga_write), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'({done1, done0}), 32'd0);
    endtask

    task automatic expectAllZero(input string tag);
        checkOutput({tag, "_x"}, 32'(vga_x), 32'd0);
        checkOutput({tag, "_y"}, 32'(vga_y), 32'd0);
        checkOutput({tag, "_colour"}, 32'(vga_colour), 32'd0);
        expectIdle(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 1'b0);
        tick();
        tick();
        expectAllZero("reset");
        reset = 1'b0;
        tick();
        expectIdle("post_reset");

        // Single 3x2 draw: raster order, done0 right after the last write.
        applyStimulus(1'b0, 10, 20, 3, 2, 5, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            expectPixel($sformatf("t1_px%0d", i), 10 + i % 3, 20 + i / 3, 5);
            tick();
        end
        expectDone("t1_done", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        expectIdle("t1_idle");

        // Zero width: straight to DONE with no writes.
        applyStimulus(1'b0, 3, 3, 0, 5, 2, 1'b1);
        tick();
        expectDone("t4_done", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        expectIdle("t4_idle");

        // Clipping at the bottom-right corner: 8 DRAW cycles, only 2 writes.
        applyStimulus(1'b1, 638, 479, 4, 2, 6, 1'b1);
        tick();
        expectPixel("t3_px0", 638, 479, 6);
        tick();
        expectPixel("t3_px1", 639, 479, 6);
        tick();
        for (int i = 2; i < 8; i++) begin
            expectBlank($sformatf("t3_clip%0d", i));
            tick();
        end
        expectDone("t3_done", 1'b0, 1'b1);
        req1 = 1'b0;
        tick();
        expectIdle("t3_idle");

        // Reset during the third pixel of a 4x4 draw.
        applyStimulus(1'b0, 100, 100, 4, 4, 7, 1'b1);
        tick();
        expectPixel("t5_px0", 100, 100, 7);
        tick();
        expectPixel("t5_px1", 101, 100, 7);
        tick();
        expectPixel("t5_px2", 102, 100, 7);
        reset = 1'b1;
        req0  = 1'b0;
        tick();
        expectAllZero("t5_reset");
        reset = 1'b0;
        tick();
        expectIdle("t5_after0");
        tick();
        expectIdle("t5_after1");

        // Contention straight after reset, with req0 held through its done.
        applyStimulus(1'b0, 0, 0, 2, 1, 1, 1'b1);
        applyStimulus(1'b1, 5, 5, 1, 1, 2, 1'b1);
        tick();
        expectPixel("c_a_px0", 0, 0, 1);
        tick();
        expectPixel("c_a_px1", 1, 0, 1);
        tick();
        expectDone("c_a_done", 1'b1, 1'b0);
`ifdef TILE_ARB_ROUND_ROBIN_EN
        tick();
        expectIdle("rr_idle0");
        tick();
        expectPixel("rr_b_px", 5, 5, 2);
        tick();
        expectDone("rr_b_done", 1'b0, 1'b1);
        req1 = 1'b0;
        tick();
        expectIdle("rr_idle1");
        tick();
        expectPixel("rr_c_px0", 0, 0, 1);
        tick();
        expectPixel("rr_c_px1", 1, 0, 1);
        tick();
        expectDone("rr_c_done", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        expectIdle("rr_idle2");
`else
        for (int r = 0; r < 2; r++) begin
            tick();
            expectIdle($sformatf("fp_idle%0d", r));
            tick();
            expectPixel($sformatf("fp_rep%0d_px0", r), 0, 0, 1);
            tick();
            expectPixel($sformatf("fp_rep%0d_px1", r), 1, 0, 1);
            tick();
            expectDone($sformatf("fp_rep%0d_done", r), 1'b1, 1'b0);
        end
        req0 = 1'b0;
        tick();
        expectIdle("fp_idle_last");
        tick();
        expectPixel("fp_b_px", 5, 5, 2);
        tick();
        expectDone("fp_b_done", 1'b0, 1'b1);
        req1 = 1'b0;
        tick();
        expectIdle("fp_idle_end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
